fireberd_capture: RTL
=====================

Name: fireberd_capture

Overview:
- Receive-side counterpart of the FIREBERD serial drive.
- Accepts the BERT's external serial clock/data pair, which is asynchronous to clk, and synchronizes it into the clk domain.
- Packs the bits into 4-bit words and buffers them in a small FIFO.
- Downstream logic (pilot/modulator path) pulls one word per request.
- Flags loss of the external clock and FIFO overflow.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the ClkIn/DataIn synchronizer chains (minimum 2).
- FIFO_DEPTH, 8, word capacity of the buffer (power of 2).
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable for all state except the synchronizer chains
- ClkIn  in  1  external serial clock from the BERT, asynchronous to clk
- DataIn  in  1  external serial data, valid at the rising edge of ClkIn
- msbFirst  in  1  1: the first received bit lands in DataOut[3]; 0: the first bit lands in DataOut[0]
- ClkTimeout  in  16  number of ce cycles without a ClkIn edge before ClkLost is declared; 0 disables detection
- ReadReq  in  1  downstream request for one word
- DataOut  out  4  word read from the FIFO
- ValidOut  out  1  one-cycle strobe qualifying DataOut
- FifoLevel  out  FIFO_AW+1  number of words currently stored
- Overflow  out  1  sticky flag: a word was dropped because the FIFO was full
- ClkLost  out  1  external clock absent

Behaviour:
- Reset (asynchronous): DataOut=0, ValidOut=0, FifoLevel=0, Overflow=0, ClkLost=0, bit count=0, shift register=0, timeout counter=0, FIFO pointers=0, synchronizers=0, edgePending=0.
- Synchronizer:
  - ClkIn and DataIn each pass through SYNC_STAGES flip-flops. These run every clk, independent of ce.
  - A rising edge is detected when the last stage is 1 and the registered copy of that stage is 0.
  - On detection, edgePending is set and the synchronized data bit is latched alongside it.
- Edge consumption:
  - The pending edge is consumed on the next cycle with ce=1.
  - A second edge arriving while one is still pending overwrites it (bit lost).
  - Requirement: ce is high at least once per half period of ClkIn.
- Bit assembly, on each consumed edge:
  - msbFirst=1: sr <= {sr[2:0], bit}.
  - msbFirst=0: sr <= {bit, sr[3:1]}.
  - The bit count increments 0→3. On the 4th bit the assembled word is written to the FIFO in the same cycle and the count wraps to 0.
  - msbFirst must be held static during a word; a change mid-word gives an undefined bit order for that word only.
- FIFO (registered output, no fall-through):
  - Read: ReadReq=1, ce=1 and not empty at cycle N → DataOut updated and ValidOut=1 at cycle N+1. ValidOut is otherwise 0 and DataOut holds its last value.
  - ReadReq while empty is ignored; no strobe is produced.
  - Write while empty in the same cycle as ReadReq: the word is stored, the read does not occur, and the word becomes readable from the next cycle.
  - Full with simultaneous read and write: both occur and the level is unchanged.
  - Full with write and no read: the word is discarded, Overflow is set to 1 and stays set until reset.
  - Pointers wrap modulo FIFO_DEPTH. FifoLevel ranges 0..FIFO_DEPTH and is updated in the cycle after each write/read.
- Clock-loss detection:
  - A counter is cleared on each consumed edge and otherwise increments on each ce cycle, saturating at ClkTimeout.
  - When the counter reaches ClkTimeout (≠0): ClkLost=1, the bit count and shift register are cleared (partial word discarded), and FIFO contents are kept.
  - ClkLost clears on the next consumed edge. That edge's bit is the first bit of a new word.
- ce=0: no assembly, FIFO or timeout activity. A pending edge is held. ValidOut=0.

Decomposition:
- Shared package holds the constants FIREBERD_WORD_BITS=4, the default FIFO_DEPTH/FIFO_AW, and the default ClkTimeout value. The same word width constant is used by the transmit-side drive.
- One sub-module: fireberd_capture_fifo, a synchronous FIFO with registered read port that provides the level, full and empty signals.
- Synchronizer, edge detection, bit assembly and the timeout logic stay in the top module.

Test Plan:
- msbFirst=0; ClkIn period 16 clk; serial bits 1,0,1,1 then 0,0,1,0; ReadReq pulsed twice after the 8th edge → ValidOut strobes with DataOut=4'hD then 4'h4, each one cycle after its request; FifoLevel goes 2→1→0.
- msbFirst=1; same bit stream → DataOut=4'hB then 4'h2.
- ReadReq held low; 40 bits (10 words) sent into FIFO_DEPTH=8 → FifoLevel=8, Overflow=1 after the 9th word. Then reading 8 times returns words 1..8 in order; Overflow remains 1.
- ClkTimeout=100; 2 bits sent, then ClkIn stopped → ClkLost=1 100 ce cycles after the last edge; FifoLevel unchanged. Clock restarted with 4 bits 0xA → one word, 0xA, is written, and ClkLost=0 after the first edge.
- Empty FIFO; ReadReq=1 held continuously while the 4th bit of a word arrives → no ValidOut in the write cycle; ValidOut=1 with the word two cycles later; no further strobes.
- Reset asserted mid-word after 2 bits, with 3 words buffered → all outputs return to their reset values immediately (asynchronously). After release, 4 new bits produce exactly one word and FifoLevel=1.

Source files
------------

// File: rtl/fireberd_capture_pkg.sv
// Shared constants and helpers for the FIREBERD serial capture/drive pair.
package fireberd_capture_pkg;

    localparam int FIREBERD_WORD_BITS = 4;
    localparam int FIREBERD_FIFO_DEPTH = 8;
    localparam int FIREBERD_FIFO_AW = 3;
    localparam logic [15:0] FIREBERD_CLK_TIMEOUT = 16'd1000;

    typedef logic [FIREBERD_WORD_BITS-1:0] word_t;

    function automatic word_t shiftInBit(input word_t sr, input logic bitIn, input logic msbFirst);
        word_t result;
        if (msbFirst) begin
            result = {sr[FIREBERD_WORD_BITS-2:0], bitIn};
        end else begin
            result = {bitIn, sr[FIREBERD_WORD_BITS-1:1]};
        end
        return result;
    endfunction

endpackage

// File: rtl/fireberd_capture_fifo.sv
// Word FIFO with a registered read port; full writes are dropped, empty reads ignored.
module fireberd_capture_fifo
    import fireberd_capture_pkg::*;
#(
    parameter int DEPTH = FIREBERD_FIFO_DEPTH,
    parameter int AW    = FIREBERD_FIFO_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wrEn,
    input  word_t       wrData,
    input  logic        rdEn,
    output word_t       rdData,
    output logic        rdValid,
    output logic [AW:0] level,
    output logic        full,
    output logic        empty
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    word_t         mem_r [DEPTH];
    logic [AW-1:0] wrPtr_r;
    logic [AW-1:0] rdPtr_r;
    logic [AW:0]   level_r;
    word_t         rdData_r;
    logic          rdValid_r;
    logic          doRead_s;
    logic          doWrite_s;

    assign empty   = (level_r == {(AW+1){1'b0}});
    assign full    = (level_r == LVL_FULL);
    assign level   = level_r;
    assign rdData  = rdData_r;
    assign rdValid = rdValid_r;

    // Qualify requests: a full FIFO accepts a write only when a read frees a slot
    always_comb begin
        doRead_s  = 1'b0;
        doWrite_s = 1'b0;
        if (rdEn && !empty) begin
            doRead_s = 1'b1;
        end else begin
            doRead_s = 1'b0;
        end
        if (wrEn && (!full || doRead_s)) begin
            doWrite_s = 1'b1;
        end else begin
            doWrite_s = 1'b0;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (doWrite_s) begin
            mem_r[wrPtr_r] <= wrData;
        end
    end

    // Pointers, level and registered read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_r   <= {AW{1'b0}};
            rdPtr_r   <= {AW{1'b0}};
            level_r   <= {(AW+1){1'b0}};
            rdData_r  <= {FIREBERD_WORD_BITS{1'b0}};
            rdValid_r <= 1'b0;
        end else begin
            rdValid_r <= doRead_s;
            if (doWrite_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (doRead_s) begin
                rdData_r <= mem_r[rdPtr_r];
                rdPtr_r  <= rdPtr_r + PTR_ONE;
            end
            case ({doWrite_s, doRead_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/fireberd_capture.sv
// Receive side of the FIREBERD link: synchronizes the BERT clock/data pair,
// packs bits into words, buffers them and watches for a missing clock.
module fireberd_capture
    import fireberd_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = FIREBERD_FIFO_DEPTH,
    parameter int FIFO_AW     = FIREBERD_FIFO_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             ClkIn,
    input  logic             DataIn,
    input  logic             msbFirst,
    input  logic [15:0]      ClkTimeout,
    input  logic             ReadReq,
    output logic [3:0]       DataOut,
    output logic             ValidOut,
    output logic [FIFO_AW:0] FifoLevel,
    output logic             Overflow,
    output logic             ClkLost
);

    localparam int             CNT_W    = $clog2(FIREBERD_WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FIREBERD_WORD_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] clkSync_r;
    logic [SYNC_STAGES-1:0] dataSync_r;
    logic                   clkPrev_r;
    logic                   edgePending_r;
    logic                   pendingBit_r;
    word_t                  sr_r;
    logic [CNT_W-1:0]       bitCnt_r;
    logic [15:0]            timeoutCnt_r;
    logic                   clkLost_r;
    logic                   overflow_r;

    logic                   riseDet_s;
    logic                   consume_s;
    logic                   wordDone_s;
    logic                   timeoutHit_s;
    logic                   fifoRead_s;
    logic                   fifoFull_s;
    logic                   fifoEmpty_s;
    word_t                  srNext_s;

    assign riseDet_s = clkSync_r[SYNC_STAGES-1] & ~clkPrev_r;
    assign consume_s = edgePending_r & ce;
    assign ClkLost   = clkLost_r;
    assign Overflow  = overflow_r;

    // Synchronizer chains and edge capture run every clk, independent of ce
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkSync_r     <= {SYNC_STAGES{1'b0}};
            dataSync_r    <= {SYNC_STAGES{1'b0}};
            clkPrev_r     <= 1'b0;
            edgePending_r <= 1'b0;
            pendingBit_r  <= 1'b0;
        end else begin
            clkSync_r  <= {clkSync_r[SYNC_STAGES-2:0], ClkIn};
            dataSync_r <= {dataSync_r[SYNC_STAGES-2:0], DataIn};
            clkPrev_r  <= clkSync_r[SYNC_STAGES-1];
            if (riseDet_s) begin
                edgePending_r <= 1'b1;
                pendingBit_r  <= dataSync_r[SYNC_STAGES-1];
            end else if (consume_s) begin
                edgePending_r <= 1'b0;
            end
        end
    end

    // Next shift value, word completion, timeout and FIFO read qualification
    always_comb begin
        srNext_s     = shiftInBit(sr_r, pendingBit_r, msbFirst);
        wordDone_s   = 1'b0;
        timeoutHit_s = 1'b0;
        fifoRead_s   = ReadReq & ce & ~fifoEmpty_s;
        if (consume_s && (bitCnt_r == LAST_BIT)) begin
            wordDone_s = 1'b1;
        end else begin
            wordDone_s = 1'b0;
        end
        if (ce && !consume_s && (ClkTimeout != 16'd0) && (timeoutCnt_r >= ClkTimeout - 16'd1)) begin
            timeoutHit_s = 1'b1;
        end else begin
            timeoutHit_s = 1'b0;
        end
    end

    // Bit assembly, clock-loss watchdog and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r         <= {FIREBERD_WORD_BITS{1'b0}};
            bitCnt_r     <= {CNT_W{1'b0}};
            timeoutCnt_r <= 16'd0;
            clkLost_r    <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (ce) begin
            if (wordDone_s && fifoFull_s && !fifoRead_s) begin
                overflow_r <= 1'b1;
            end
            if (consume_s) begin
                sr_r         <= srNext_s;
                bitCnt_r     <= wordDone_s ? {CNT_W{1'b0}} : bitCnt_r + CNT_ONE;
                timeoutCnt_r <= 16'd0;
                clkLost_r    <= 1'b0;
            end else if (ClkTimeout == 16'd0) begin
                timeoutCnt_r <= 16'd0;
                clkLost_r    <= 1'b0;
            end else if (timeoutHit_s) begin
                // Partial word is meaningless once the clock has gone away
                timeoutCnt_r <= ClkTimeout;
                clkLost_r    <= 1'b1;
                sr_r         <= {FIREBERD_WORD_BITS{1'b0}};
                bitCnt_r     <= {CNT_W{1'b0}};
            end else begin
                timeoutCnt_r <= timeoutCnt_r + 16'd1;
            end
        end
    end

    fireberd_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wrEn    (wordDone_s),
        .wrData  (srNext_s),
        .rdEn    (fifoRead_s),
        .rdData  (DataOut),
        .rdValid (ValidOut),
        .level   (FifoLevel),
        .full    (fifoFull_s),
        .empty   (fifoEmpty_s)
    );

endmodule
